cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port req_valid, input, 4, per-requester result valid; index 0=int, 1=lw_sw, 2=mult, 3=div.
REQ-004 SHALL have port req_pkt, input, 4 x cdb_pkt, per-requester result: tag[6:0], data[31:0], branch, branch_taken.
REQ-005 SHALL have port req_ready, output, 4, per-requester acceptance; a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-006 SHALL have port cdb_valid, output, 1, broadcast valid.
REQ-007 SHALL have port cdb_tag, output, 7, broadcast tag.
REQ-008 SHALL have port cdb_data, output, 32, broadcast data.
REQ-009 SHALL have port cdb_branch, output, 1, broadcast is a branch resolution.
REQ-010 SHALL have port cdb_branch_taken, output, 1, 1=taken, 0=not taken.
REQ-011 SHALL have exactly one clock and an asynchronous active-high reset, as already decided.

Function
REQ-012 SHALL hold one entry per requester: hold_vld[i] and hold_pkt[i].
REQ-013 SHALL drive req_ready[i] = ~hold_vld[i] | grant[i].
- grant depends only on registered state, never on req_valid, so there is no combinational loop.
REQ-014 SHALL capture req_pkt[i] into hold_pkt[i] and set hold_vld[i] on each transfer.
REQ-015 SHALL each cycle grant at most one requester among those with hold_vld set.
- Search is round-robin starting at pointer rr_ptr[1:0], in index order rr_ptr, rr_ptr+1, ... modulo 4.
REQ-016 SHALL register the granted hold_pkt onto the cdb_* outputs with cdb_valid=1 at the next edge.
- The same edge clears hold_vld of the winner, unless the winner is refilled that same edge.
- The same edge sets rr_ptr to (winner index + 1) mod 4, wrapping from 3 to 0.
REQ-017 SHALL, in a cycle with no grant, drive cdb_valid=0 and cdb_tag, cdb_data, cdb_branch and cdb_branch_taken to 0 at the next edge, and leave rr_ptr unchanged.
REQ-018 SHALL apply a fixed latency when the bus is uncontended: transfer at edge k gives cdb_valid=1 after edge k+1.
REQ-019 SHALL sustain one broadcast per cycle from a single requester streaming back-to-back, by refilling at the same edge it is granted.
REQ-020 SHALL grant every occupied hold entry within 4 cycles of it becoming occupied.
REQ-021 SHALL keep a non-granted occupied entry stable, and keep its req_ready low.
REQ-022 SHALL pass all cdb_pkt fields unmodified; no arithmetic or width change is allowed.

Reset
REQ-023 SHALL, on rst assertion at any time including mid-broadcast, asynchronously clear hold_vld to 0, rr_ptr to 0 and all cdb_* outputs to 0.
REQ-024 SHALL drive req_ready=4'b1111 while rst is high and on the first cycle after release.
REQ-025 SHALL drop any packet whose transfer coincides with rst high.

Structure
REQ-026 SHALL define the cdb_pkt typedef and the requester index constants (INT=0, LWSW=1, MULT=2, DIV=3) in the shared variables.sv package.
REQ-027 SHALL implement the grant logic in one sub-module, rr_arbiter4.
- Inputs: 4-bit request vector and 2-bit pointer.
- Outputs: one-hot grant and a 2-bit winner index.
- Purely combinational; the parent owns rr_ptr.

Verification
REQ-028 SHALL cover the single request: int sends tag=7'h05, data=32'hDEAD_BEEF at edge 1 -> cdb_valid=1, tag=05, data=DEADBEEF after edge 2, then cdb_valid=0 after edge 3.
REQ-029 SHALL cover simultaneous requests: all 4 send at edge 1 with rr_ptr=0, tags 10, 11, 12, 13 -> broadcasts of tags 10, 11, 12, 13 after edges 2, 3, 4, 5, and req_ready low for each waiting entry.
REQ-030 SHALL cover fairness and wrap-around: with rr_ptr=3, div and int both pending -> div is granted first, rr_ptr becomes 0, then int is granted and rr_ptr becomes 1.
REQ-031 SHALL cover streaming: mult holds req_valid high for 5 cycles with tags 20-24 and no other traffic -> 5 consecutive broadcasts and req_ready[2] held at 1.
REQ-032 SHALL cover branch pass-through: lw_sw sends branch=1, branch_taken=1, tag=7'h3F -> cdb_branch=1 and cdb_branch_taken=1 with tag 3F on the broadcast cycle.
REQ-033 SHALL cover reset mid-operation: rst asserted mid-cycle with 3 entries pending and cdb_valid=1 -> all outputs 0 immediately, nothing broadcast after release, and req_ready=1111.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared packet type and requester indices for the CDB arbiter
package cdb_arbiter_pkg;
    localparam int NREQ = 4;
    localparam int INT  = 0;
    localparam int LWSW = 1;
    localparam int MULT = 2;
    localparam int DIV  = 3;

    typedef struct packed {
        logic [6:0]  tag;
        logic [31:0] data;
        logic        branch;
        logic        branch_taken;
    } cdb_pkt_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester handshake and broadcast bus of the CDB arbiter
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;
    logic [NREQ-1:0]           req_valid;
    cdb_pkt_t [NREQ-1:0]       req_pkt;
    logic [NREQ-1:0]           req_ready;
    logic                      cdb_valid;
    logic [6:0]                cdb_tag;
    logic [31:0]               cdb_data;
    logic                      cdb_branch;
    logic                      cdb_branch_taken;

    modport master (
        output req_valid, req_pkt,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken
    );
    modport slave (
        input  req_valid, req_pkt,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken
    );
endinterface

// File: rtl/cdb_arbiter_rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin pick starting at ptr_i
module rr_arbiter4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] grant_o,
    output logic [1:0] idx_o
);
    logic [1:0] j;

    // scan from farthest to nearest offset so the nearest requester wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        j       = '0;
        for (int k = 3; k >= 0; k--) begin
            j = ptr_i + 2'(k);
            if (req_i[j]) begin
                grant_o = 4'b0001 << j;
                idx_o   = j;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-requester hold slots, round-robin grant, registered CDB broadcast
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input logic         clk,
    input logic         rst,
    cdb_arbiter_if.slave bus
);
    logic [NREQ-1:0]     hold_vld_q, hold_vld_d, grant, ready, xfer;
    cdb_pkt_t [NREQ-1:0] hold_pkt_q, hold_pkt_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d, win;
    logic                cdb_valid_q, cdb_valid_d;
    cdb_pkt_t            cdb_pkt_q, cdb_pkt_d;

    rr_arbiter4 u_arb (
        .req_i  (hold_vld_q),
        .ptr_i  (rr_ptr_q),
        .grant_o(grant),
        .idx_o  (win)
    );

    // a granted slot frees up this edge, so it can be refilled while it broadcasts
    assign ready         = ~hold_vld_q | grant;
    assign xfer          = bus.req_valid & ready;
    assign bus.req_ready = ready;

    // next state: free the winner, capture new transfers, broadcast or idle with zeros
    always_comb begin
        hold_vld_d  = (hold_vld_q & ~grant) | xfer;
        hold_pkt_d  = hold_pkt_q;
        for (int i = 0; i < NREQ; i++)
            hold_pkt_d[i] = xfer[i] ? bus.req_pkt[i] : hold_pkt_q[i];
        cdb_valid_d = |grant;
        cdb_pkt_d   = |grant ? hold_pkt_q[win] : '0;
        rr_ptr_d    = |grant ? win + 2'd1 : rr_ptr_q;
    end

    // state registers; reset empties every slot and silences the bus immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld_q  <= '0;
            hold_pkt_q  <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_pkt_q   <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_pkt_q  <= hold_pkt_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_pkt_q   <= cdb_pkt_d;
        end
    end

    assign bus.cdb_valid        = cdb_valid_q;
    assign bus.cdb_tag          = cdb_pkt_q.tag;
    assign bus.cdb_data         = cdb_pkt_q.data;
    assign bus.cdb_branch       = cdb_pkt_q.branch;
    assign bus.cdb_branch_taken = cdb_pkt_q.branch_taken;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random checks of cdb_arbiter against a slot/queue model
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cdb_arbiter_if bus ();
    cdb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    bit       m_vld [4];
    cdb_pkt_t m_pkt [4];
    int       m_ptr;
    bit       m_cv;
    cdb_pkt_t m_cdb;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int m_winner();
        for (int k = 0; k < 4; k++)
            if (m_vld[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        int w = m_winner();
        for (int i = 0; i < 4; i++) r[i] = !m_vld[i] || (w == i);
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_vld[i] = 0;
            m_pkt[i] = '0;
        end
        m_ptr = 0;
        m_cv  = 0;
        m_cdb = '0;
    endtask

    task automatic check_cdb(input string name);
        chk({name, ".valid"}, 64'(bus.cdb_valid), 64'(m_cv));
        chk({name, ".tag"}, 64'(bus.cdb_tag), 64'(m_cdb.tag));
        chk({name, ".data"}, 64'(bus.cdb_data), 64'(m_cdb.data));
        chk({name, ".br"}, 64'(bus.cdb_branch), 64'(m_cdb.branch));
        chk({name, ".taken"}, 64'(bus.cdb_branch_taken), 64'(m_cdb.branch_taken));
    endtask

    // one clock: check ready, advance model across the edge, check broadcast
    task automatic tick(input string name);
        logic [3:0] r, x;
        int w;
        #1;
        r = m_ready();
        chk({name, ".ready"}, 64'(bus.req_ready), 64'(r));
        x = bus.req_valid & r;
        w = m_winner();
        @(posedge clk);
        if (w >= 0) begin
            m_cv  = 1;
            m_cdb = m_pkt[w];
            m_vld[w] = 0;
            m_ptr = (w + 1) % 4;
        end else begin
            m_cv  = 0;
            m_cdb = '0;
        end
        for (int i = 0; i < 4; i++)
            if (x[i]) begin
                m_vld[i] = 1;
                m_pkt[i] = bus.req_pkt[i];
            end
        #1;
        check_cdb(name);
    endtask

    task automatic put(input int i, input logic [6:0] tag, input logic [31:0] data,
                       input logic br, input logic tk);
        bus.req_valid[i]            = 1'b1;
        bus.req_pkt[i].tag          = tag;
        bus.req_pkt[i].data         = data;
        bus.req_pkt[i].branch       = br;
        bus.req_pkt[i].branch_taken = tk;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_pkt   = '0;
        m_reset();
        #3;
        chk("rst.valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst.ready", 64'(bus.req_ready), 64'hF);
        @(posedge clk);
        #1 rst = 1'b0;

        put(INT, 7'h05, 32'hDEAD_BEEF, 0, 0);
        tick("single.e1");
        bus.req_valid = '0;
        tick("single.e2");
        chk("single.valid", 64'(bus.cdb_valid), 64'd1);
        chk("single.tag", 64'(bus.cdb_tag), 64'h05);
        chk("single.data", 64'(bus.cdb_data), 64'hDEADBEEF);
        tick("single.e3");
        chk("single.idle", 64'(bus.cdb_valid), 64'd0);

        put(DIV, 7'h01, 32'h1, 0, 0);
        tick("ptr0.a");
        bus.req_valid = '0;
        tick("ptr0.b");
        for (int i = 0; i < 4; i++) put(i, 7'(8'h10 + i), 32'(i * 3 + 7), 0, 0);
        tick("all.e1");
        bus.req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            tick("all.drain");
            chk("all.tag", 64'(bus.cdb_tag), 64'(8'h10 + i));
        end
        tick("all.idle");

        put(MULT, 7'h02, 32'h2, 0, 0);
        tick("wrap.m1");
        bus.req_valid = '0;
        put(DIV, 7'h33, 32'h33, 0, 0);
        put(INT, 7'h30, 32'h30, 0, 0);
        tick("wrap.m2");
        bus.req_valid = '0;
        tick("wrap.div");
        chk("wrap.div.tag", 64'(bus.cdb_tag), 64'h33);
        tick("wrap.int");
        chk("wrap.int.tag", 64'(bus.cdb_tag), 64'h30);

        for (int i = 0; i < 5; i++) begin
            put(MULT, 7'(8'h20 + i), 32'(100 + i), 0, 0);
            #1 chk("stream.ready2", 64'(bus.req_ready[MULT]), 64'd1);
            tick("stream");
            if (i > 0) chk("stream.tag", 64'(bus.cdb_tag), 64'(8'h20 + i - 1));
        end
        bus.req_valid = '0;
        tick("stream.last");
        chk("stream.last.tag", 64'(bus.cdb_tag), 64'h24);

        put(LWSW, 7'h3F, 32'hCAFE_0001, 1, 1);
        tick("br.e1");
        bus.req_valid = '0;
        tick("br.e2");
        chk("br.branch", 64'(bus.cdb_branch), 64'd1);
        chk("br.taken", 64'(bus.cdb_branch_taken), 64'd1);
        chk("br.tag", 64'(bus.cdb_tag), 64'h3F);

        for (int i = 0; i < 4; i++) put(i, 7'(8'h40 + i), 32'(i), 0, 0);
        tick("mid.load");
        bus.req_valid = '0;
        tick("mid.bcast");
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_cdb("mid.rst");
        chk("mid.rst.ready", 64'(bus.req_ready), 64'hF);
        put(INT, 7'h55, 32'h55, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.req_valid = '0;
        tick("mid.after1");
        tick("mid.after2");
        chk("mid.after.valid", 64'(bus.cdb_valid), 64'd0);

        for (int n = 0; n < 300; n++) begin
            bus.req_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                bus.req_pkt[i].tag          = 7'($urandom);
                bus.req_pkt[i].data         = $urandom;
                bus.req_pkt[i].branch       = 1'($urandom);
                bus.req_pkt[i].branch_taken = 1'($urandom);
            end
            tick("rand");
        end
        bus.req_valid = '0;
        for (int n = 0; n < 5; n++) tick("rand.drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
